alu_legv8: RTL and testbench



---
 rtl/alu_legv8_pkg.sv | 23 ++
 rtl/alu_legv8_if.sv | 21 ++
 rtl/alu_legv8_adder.sv | 28 ++
 rtl/alu_legv8.sv | 115 +++++++++++
 tb/tb_alu_legv8.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_legv8_pkg.sv
// alu_legv8_pkg: shared opcode, flag-index and width constants for the LEGv8 ALU.
// Revision: 1.0
`default_nettype none

package alu_legv8_pkg;

  localparam int DATA_W_DEFAULT = 64;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

`default_nettype wire

// File: rtl/alu_legv8_if.sv
// alu_legv8_if: operand/function/result bundle between the core and the ALU.
// Revision: 1.0
`default_nettype none

interface alu_legv8_if
  import alu_legv8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [4:0]        FS;
  logic              C0;
  logic [DATA_W-1:0] F;
  logic [3:0]        status;

  modport master (output A, B, FS, C0, input  F, status);
  modport slave  (input  A, B, FS, C0, output F, status);
endinterface

`default_nettype wire

// File: rtl/alu_legv8_adder.sv
// alu_legv8_adder: DATA_W-bit a+b+cin with carry-out and signed-overflow outputs.
// Revision: 1.0
`default_nettype none

module alu_legv8_adder
  import alu_legv8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  wire logic [DATA_W-1:0] a_i,
  input  wire logic [DATA_W-1:0] b_i,
  input  wire logic              cin_i,
  output logic      [DATA_W-1:0] sum_o,
  output logic                   cout_o,
  output logic                   ovf_o
);

  logic [DATA_W:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
  assign sum_o  = full[DATA_W-1:0];
  assign cout_o = full[DATA_W];
  // Same-sign operands producing an opposite-sign sum is a signed overflow.
  assign ovf_o  = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum_o[DATA_W-1] != a_i[DATA_W-1]);

endmodule

`default_nettype wire

// File: rtl/alu_legv8.sv
// alu_legv8: LEGv8 ALU (AND/OR/ADD/XOR/LSL/LSR) with registered result and {V,C,N,Z}.
// Optional input register stage enabled by defining ALU_LEGV8_INPUT_REG_EN. Revision: 1.0
`default_nettype none

module alu_legv8
  import alu_legv8_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  wire logic   clock,
  input  wire logic   reset_n,
  alu_legv8_if.slave  bus
);

  logic [DATA_W-1:0]  a_in;
  logic [DATA_W-1:0]  b_in;
  logic [4:0]         fs_in;
  logic               c0_in;

`ifdef ALU_LEGV8_INPUT_REG_EN
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [4:0]         fs_q;
  logic               c0_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      fs_q <= '0;
      c0_q <= 1'b0;
    end else begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      fs_q <= bus.FS;
      c0_q <= bus.C0;
    end
  end

  assign a_in  = a_q;
  assign b_in  = b_q;
  assign fs_in = fs_q;
  assign c0_in = c0_q;
`else
  assign a_in  = bus.A;
  assign b_in  = bus.B;
  assign fs_in = bus.FS;
  assign c0_in = bus.C0;
`endif

  logic [DATA_W-1:0]  a_eff;
  logic [DATA_W-1:0]  b_eff;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         op;
  logic [DATA_W-1:0]  sum;
  logic               cout;
  logic               ovf;

  assign a_eff = fs_in[0] ? ~a_in : a_in;
  assign b_eff = fs_in[1] ? ~b_in : b_in;
  // Shift amount comes from the raw operand, never the inverted one.
  assign shamt = b_in[SHAMT_W-1:0];
  assign op    = fs_in[4:2];

  alu_legv8_adder #(.DATA_W(DATA_W)) u_adder (
    .a_i    (a_eff),
    .b_i    (b_eff),
    .cin_i  (c0_in),
    .sum_o  (sum),
    .cout_o (cout),
    .ovf_o  (ovf)
  );

  logic [DATA_W-1:0]  f_d;
  logic [3:0]         status_d;
  logic [DATA_W-1:0]  f_q;
  logic [3:0]         status_q;

  always_comb begin
    f_d      = '0;
    status_d = '0;
    case (op)
      OP_AND:  f_d = a_eff & b_eff;
      OP_OR:   f_d = a_eff | b_eff;
      OP_ADD: begin
        f_d              = sum;
        status_d[FLAG_C] = cout;
        status_d[FLAG_V] = ovf;
      end
      OP_XOR:  f_d = a_eff ^ b_eff;
      OP_LSL:  f_d = a_eff << shamt;
      OP_LSR:  f_d = a_eff >> shamt;
      default: f_d = '0;
    endcase
    status_d[FLAG_N] = f_d[DATA_W-1];
    status_d[FLAG_Z] = (f_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f_q      <= '0;
      status_q <= '0;
    end else begin
      f_q      <= f_d;
      status_q <= status_d;
    end
  end

  assign bus.F      = f_q;
  assign bus.status = status_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_legv8.sv
// tb_alu_legv8: directed vectors plus a spec-level reference model compared every cycle.
// Revision: 1.0
`default_nettype none

module tb_alu_legv8;

`ifdef ALU_LEGV8_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic cmp_en  = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  alu_legv8_if bus ();

  alu_legv8 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference: status in [67:64] as {V,C,N,Z}, result in [63:0].
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [4:0] fs, input logic c0);
    logic [63:0]        ae, be, r;
    logic               c, v;
    logic [64:0]        wide;
    logic signed [65:0] s;
    ae = fs[0] ? ~a : a;
    be = fs[1] ? ~b : b;
    r = 64'd0; c = 1'b0; v = 1'b0;
    case (fs[4:2])
      3'd0: r = ae & be;
      3'd1: r = ae | be;
      3'd2: begin
        wide = {1'b0, ae} + {1'b0, be} + {64'd0, c0};
        r    = wide[63:0];
        c    = wide[64];
        s    = $signed({{2{ae[63]}}, ae}) + $signed({{2{be[63]}}, be}) + $signed({65'd0, c0});
        v    = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
      end
      3'd3: r = ae ^ be;
      3'd4: r = ae << b[5:0];
      3'd5: r = ae >> b[5:0];
      default: r = 64'd0;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got status=%b F=%h, expected status=%b F=%h",
                  nm, act[67:64], act[63:0], exp[67:64], exp[63:0]);
  endtask

  // Model pipeline tracking the DUT latency.
  logic [67:0] exp_q  = '0;
  logic [67:0] stg1_q = '0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q  = '0;
      stg1_q = model('0, '0, '0, 1'b0);
    end else if (LAT == 2) begin
      exp_q  = stg1_q;
      stg1_q = model(bus.A, bus.B, bus.FS, bus.C0);
    end else begin
      exp_q  = model(bus.A, bus.B, bus.FS, bus.C0);
    end
  end

  always @(negedge clock) begin
    if (cmp_en) chk("model", {bus.status, bus.F}, exp_q);
  end

  task automatic drv(input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] fs, input logic c0);
    bus.A  = a;
    bus.B  = b;
    bus.FS = fs;
    bus.C0 = c0;
  endtask

  task automatic vec(input string nm, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] fs, input logic c0,
                     input logic [63:0] ef, input logic [3:0] es);
    @(negedge clock);
    drv(a, b, fs, c0);
    repeat (LAT) @(posedge clock);
    #1;
    chk(nm, {bus.status, bus.F}, {es, ef});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    drv('0, '0, '0, 1'b0);
    #2;
    chk("reset_state", {bus.status, bus.F}, 68'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    vec("sub_5_3",  64'd5, 64'd3, 5'b01010, 1'b1, 64'd2, 4'b0100);
    vec("sub_3_5",  64'd3, 64'd5, 5'b01010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
    vec("ovf_add",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0,
        64'h8000_0000_0000_0000, 4'b1010);
    vec("wrap_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'd0, 4'b0101);
    vec("and",      64'hF0F0, 64'hFF00, 5'b00000, 1'b0, 64'hF000, 4'b0000);
    vec("or",       64'hF0F0, 64'hFF00, 5'b00100, 1'b0, 64'hFFF0, 4'b0000);
    vec("xor",      64'hF0F0, 64'hFF00, 5'b01100, 1'b0, 64'h0FF0, 4'b0000);
    vec("nor",      64'd0, 64'd0, 5'b00011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
    vec("lsl_63",   64'd1, 64'd63, 5'b10000, 1'b0, 64'h8000_0000_0000_0000, 4'b0010);
    vec("lsr_b104", 64'h8000_0000_0000_0000, 64'h104, 5'b10100, 1'b0,
        64'h0800_0000_0000_0000, 4'b0000);
    vec("lsl_0",    64'h1234, 64'h40, 5'b10000, 1'b0, 64'h1234, 4'b0000);
    vec("lsr_invb", 64'hF0, 64'h4, 5'b10110, 1'b0, 64'h0F, 4'b0000);

    // Asynchronous reset with no clock edge, then recovery.
    vec("add_pre",  64'd7, 64'd8, 5'b01000, 1'b0, 64'd15, 4'b0000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {bus.status, bus.F}, 68'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    drv(64'd1, 64'd1, 5'b01000, 1'b0);
    repeat (LAT) @(posedge clock);
    #1;
    chk("post_rst", {bus.status, bus.F}, {4'b0000, 64'd2});

    for (int f = 24; f < 32; f++) begin
      vec($sformatf("undef_%0d", f), {$urandom, $urandom}, {$urandom, $urandom},
          5'(f), 1'b1, 64'd0, 4'b0001);
    end

    for (int f = 0; f < 32; f++) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          drv({$urandom, $urandom}, {$urandom, $urandom}, 5'(f), 1'(c));
        end
      end
    end

    repeat (LAT + 1) @(negedge clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
